// File: rtl/program_loader.sv
// Boot loader: assembles 19-bit instructions from a host byte stream and writes
// them to instruction memory from address 0, holding the core until the load completes.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | after reset, waiting for start; core held
// LEN_LO  | waiting for low byte of instruction count
// LEN_HI  | waiting for high nibble of instruction count
// B0      | waiting for instruction bits [7:0]
// B1      | waiting for instruction bits [15:8]
// B2      | waiting for instruction bits [18:16]
// WRITE   | one-cycle memory write of the assembled instruction
// DONE    | program loaded, core released
// ERROR   | malformed stream, core held
module program_loader #(
    parameter int INSTR_LEN = 19,
    parameter int ADDR_LEN  = 12,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 im_we,
    output logic [ADDR_LEN-1:0]  im_addr,
    output logic [INSTR_LEN-1:0] im_wdata,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_LEN:0]    words_written
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LEN_LO = 4'd1;
    localparam logic [3:0] S_LEN_HI = 4'd2;
    localparam logic [3:0] S_B0     = 4'd3;
    localparam logic [3:0] S_B1     = 4'd4;
    localparam logic [3:0] S_B2     = 4'd5;
    localparam logic [3:0] S_WRITE  = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERROR  = 4'd8;

    localparam logic [13:0] DEPTH_LIM = 14'(MEM_DEPTH);

    logic [3:0]          state;
    logic [3:0]          state_nxt;
    logic [7:0]          count_lo;
    logic [7:0]          byte0;
    logic [7:0]          byte1;
    logic [ADDR_LEN:0]   count;
    logic [ADDR_LEN:0]   ww_inc;
    logic [12:0]         hdr_raw;
    logic                hdr_bad;
    logic                accept;
    logic                can_start;

    assign accept    = in_valid && in_ready;
    assign hdr_raw   = {1'b0, in_data[3:0], count_lo};
    // Count is 13 bits wide so a full MEM_DEPTH program can be expressed and compared.
    assign hdr_bad   = (in_data[7:4] != 4'd0) || ({1'b0, hdr_raw} > DEPTH_LIM);
    assign ww_inc    = words_written + 1'b1;
    assign can_start = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LEN_LO;
            S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (hdr_bad)
                        state_nxt = S_ERROR;
                    else if (hdr_raw == 13'd0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_B0;
                end
            end
            S_B0:     if (accept) state_nxt = S_B1;
            S_B1:     if (accept) state_nxt = S_B2;
            S_B2: begin
                if (accept)
                    state_nxt = (in_data[7:3] != 5'd0) ? S_ERROR : S_WRITE;
            end
            S_WRITE:  state_nxt = (ww_inc == count) ? S_DONE : S_B0;
            S_DONE:   if (start) state_nxt = S_LEN_LO;
            S_ERROR:  if (start) state_nxt = S_LEN_LO;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered copies of the next state so they change with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            in_ready      <= 1'b0;
            im_we         <= 1'b0;
            im_addr       <= '0;
            im_wdata      <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
            count_lo      <= '0;
            count         <= '0;
            byte0         <= '0;
            byte1         <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt inside {S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2};
            im_we    <= (state_nxt == S_WRITE);
            busy     <= state_nxt inside {S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_WRITE};
            done     <= (state_nxt == S_DONE);
            err      <= (state_nxt == S_ERROR);
            cpu_hold <= (state_nxt != S_DONE);

            if (can_start) begin
                words_written <= '0;
                im_addr       <= '0;
            end

            if (accept) begin
                case (state)
                    S_LEN_LO: count_lo <= in_data;
                    S_LEN_HI: count    <= (ADDR_LEN + 1)'(hdr_raw);
                    S_B0:     byte0    <= in_data;
                    S_B1:     byte1    <= in_data;
                    S_B2: begin
                        if (in_data[7:3] == 5'd0)
                            im_wdata <= INSTR_LEN'({in_data[2:0], byte1, byte0});
                    end
                    default: ;
                endcase
            end

            if (state == S_WRITE) begin
                im_addr       <= im_addr + 1'b1;
                words_written <= ww_inc;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: byte streams with optional random
// backpressure, compared against a stream-level reference model.
module tb_program_loader;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        im_we;
    logic [11:0] im_addr;
    logic [18:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] words_written;

    program_loader #(.INSTR_LEN(19), .ADDR_LEN(12), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write capture
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic        prev_we = 1'b0;
    int          we_run_err = 0;
    int          hold_err = 0;

    always @(negedge clk) begin
        if (im_we) begin
            cap_addr.push_back(32'(im_addr));
            cap_data.push_back(32'(im_wdata));
            if (prev_we) we_run_err++;
        end
        prev_we = im_we;
        if (busy && !cpu_hold) hold_err++;
    end

    // Reference model: interprets the byte stream directly
    logic [7:0]  stream[$];
    int          exp_consumed;
    bit          exp_ok;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          send_ok;

    task automatic model_run();
        int cnt;
        exp_addr.delete();
        exp_data.delete();
        cnt = int'(stream[0]) + 256 * (int'(stream[1]) % 16);
        if (int'(stream[1]) >= 16 || cnt > DEPTH) begin
            exp_consumed = 2;
            exp_ok = 0;
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            int b0, b1, b2;
            b0 = int'(stream[2 + 3*i]);
            b1 = int'(stream[3 + 3*i]);
            b2 = int'(stream[4 + 3*i]);
            if (b2 > 7) begin
                exp_consumed = 5 + 3*i;
                exp_ok = 0;
                return;
            end
            exp_addr.push_back(32'(i));
            exp_data.push_back(32'(b2 * 65536 + b1 * 256 + b0));
        end
        exp_consumed = 2 + 3*cnt;
        exp_ok = 1;
    endtask

    task automatic send_stream(input int n, input bit bp, output bit ok);
        ok = 1;
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            bit sent = 0;
            while (!sent) begin
                @(negedge clk);
                if (bp && $urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data  = stream[k];
                end
                if (in_valid && in_ready) begin
                    @(posedge clk);
                    sent = 1;
                end else begin
                    guard++;
                    if (guard > 100) begin
                        check("byte_timeout", 32'(in_ready), 32'd1);
                        ok = 0;
                        return;
                    end
                end
            end
        end
    endtask

    task automatic run_session(input bit bp, input string tag);
        int nw;
        cap_addr.delete();
        cap_data.delete();
        model_run();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy0"}, 32'(busy), 32'd1);
        check({tag, "_hold0"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done0"}, 32'(done), 32'd0);
        check({tag, "_ww0"}, 32'(words_written), 32'd0);
        send_stream(exp_consumed, bp, send_ok);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_we_last"}, 32'(im_we), 32'(exp_ok && exp_addr.size() > 0));
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(exp_ok));
        check({tag, "_err"}, 32'(err), 32'(!exp_ok));
        repeat (3) @(negedge clk);
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_ok));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_ww"}, 32'(words_written), 32'(exp_addr.size()));
        check({tag, "_addr_end"}, 32'(im_addr), 32'(exp_addr.size()));
        check({tag, "_nwrites"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
        nw = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
        for (int i = 0; i < nw; i++) begin
            check({tag, "_waddr"}, cap_addr[i], exp_addr[i]);
            check({tag, "_wdata"}, cap_data[i], exp_data[i]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(im_we), 32'd0);
        check({tag, "_addr"}, 32'(im_addr), 32'd0);
        check({tag, "_wdata"}, 32'(im_wdata), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_ww"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold", 32'(cpu_hold), 32'd1);
        check("idle_ready", 32'(in_ready), 32'd0);

        stream = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h02, 8'h07};
        run_session(0, "basic");
        run_session(1, "bp");

        stream = '{8'h00, 8'h00};
        run_session(0, "zero");

        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'h08};
        run_session(0, "bad_b2");
        stream = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h02, 8'h07};
        run_session(1, "recover");

        stream = '{8'h01, 8'h10};
        run_session(0, "hdr_nib");
        stream = '{8'h11, 8'h00};
        run_session(0, "hdr_over");

        // Reset after the second instruction's B1 byte
        cap_addr.delete();
        cap_data.delete();
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_stream(7, 0, send_ok);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h06;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        check("midrst_nwrites", 32'(cap_addr.size()), 32'd1);
        if (cap_data.size() > 0) check("midrst_wdata", cap_data[0], 32'h32211);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);

        for (int s = 0; s < 10; s++) begin
            int cnt;
            cnt = (s == 0) ? DEPTH : $urandom_range(0, DEPTH);
            stream.delete();
            stream.push_back(8'(cnt % 256));
            if ($urandom_range(0, 9) == 0)
                stream.push_back(8'($urandom_range(16, 255)));
            else
                stream.push_back(8'(cnt / 256));
            for (int i = 0; i < cnt; i++) begin
                stream.push_back(8'($urandom));
                stream.push_back(8'($urandom));
                if ($urandom_range(0, 19) == 0)
                    stream.push_back(8'($urandom_range(8, 255)));
                else
                    stream.push_back(8'($urandom_range(0, 7)));
            end
            run_session(bit'($urandom_range(0, 1)), $sformatf("rnd%0d", s));
        end

        check("single_cycle_we", 32'(we_run_err), 32'd0);
        check("hold_while_busy", 32'(hold_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time writer for the core's instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles 19-bit instructions. It writes them to consecutive instruction-memory addresses starting at 0.
- While loading, it holds the pipelined core in reset via cpu_hold. It releases the core only after the whole program has been written.
- Sits between the external host/byte link and the instruction memory write port. The core's fetch stage is the reader of the same memory.

Parameters:
- INSTR_LEN, 19, instruction width written to memory.
- ADDR_LEN, 12, instruction-memory address width.
- MEM_DEPTH, 4096, number of writable instruction slots; bounds the legal program length.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (rst==0 sampled at a rising edge resets the block).
- start  input  1  one-cycle pulse; begins a load session.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept a byte.
- im_we  output  1  instruction-memory write enable.
- im_addr  output  ADDR_LEN  write address.
- im_wdata  output  INSTR_LEN  write data.
- cpu_hold  output  1  holds core in reset while 1.
- busy  output  1  session in progress.
- done  output  1  program loaded successfully.
- err  output  1  session aborted on malformed stream.
- words_written  output  ADDR_LEN+1  count of instructions written in current session.

Behaviour:
- Reset (rst==0 at edge):
  - State goes to IDLE.
  - in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, words_written=0, cpu_hold=1.
  - The core stays held until a successful load.
  - Reset mid-session aborts immediately. Memory contents already written are left as-is.
- Byte transfer: a byte transfers only on a cycle where in_valid && in_ready. in_ready=1 only in LEN_LO, LEN_HI, B0, B1, B2. The host may hold in_valid indefinitely; no byte is consumed while in_ready=0.
- FSM:
  - IDLE: on start, go to LEN_LO and clear words_written/im_addr/done/err. Set busy=1 and cpu_hold=1.
  - LEN_LO: accepted byte -> count[7:0].
  - LEN_HI: accepted byte -> count[11:8] from in_data[3:0].
    - in_data[7:4]!=0, or assembled count > MEM_DEPTH, goes to ERROR.
    - count==0 goes to DONE.
    - Otherwise go to B0.
  - B0: byte -> instr[7:0].
  - B1: byte -> instr[15:8].
  - B2: byte -> instr[18:16] from in_data[2:0]. in_data[7:3]!=0 goes to ERROR; otherwise go to WRITE.
  - WRITE (exactly one cycle):
    - im_we=1, im_addr=current address, im_wdata=assembled instruction.
    - Next cycle: address+1 and words_written+1.
    - If words_written+1==count, go to DONE; else go to B0.
  - DONE: busy=0, done=1, cpu_hold=0. Remains until start, which begins a new session (done cleared, cpu_hold=1 in the same transition).
  - ERROR: busy=0, err=1, cpu_hold=1. Remains until start, which restarts as from IDLE.
- start is ignored in LEN_LO..WRITE.
- Latency: the B2 byte is accepted at edge N; im_we is high during the cycle after N.
  - Minimum throughput is 4 cycles per instruction: 3 bytes plus 1 write.
  - After the final WRITE, done=1 on the next cycle.
- Address never wraps, since count <= MEM_DEPTH <= 2^ADDR_LEN. im_addr after the last write equals count (its low ADDR_LEN bits).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then start; stream 03 00 | 34 12 05 | FF 00 00 | 01 02 07 with in_valid held high.
  - Required writes: addr0=0x51234, addr1=0x000FF, addr2=0x70201, each with im_we high for one cycle.
  - Then done=1, cpu_hold=0, words_written=3.
- Backpressure: toggle in_valid randomly during the same stream. Writes and data must be identical, and no byte may be lost or duplicated.
- Header 00 00: no im_we. done=1 and cpu_hold=0 two cycles after the LEN_HI byte is accepted.
- Malformed byte: header 01 00, instruction bytes AA BB 08. err=1, no write, cpu_hold stays 1, in_ready=0. A subsequent start plus a valid stream recovers to done=1.
- Header 01 10 (LEN_HI upper nibble nonzero) goes to ERROR. With MEM_DEPTH=16, header 11 00 (count 17) goes to ERROR.
- Drive rst=0 for one edge after the second instruction's B1 byte. All outputs must equal their reset values next cycle, cpu_hold=1, and no further im_we occurs.
